// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that owns the HI/LO registers. It runs shift-add
// multiply and restoring divide over WIDTH cycles, and also handles mthi/mtlo/mfhi/mflo.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [3:0]       ALU_control,
    input  logic             do_unsigned,
    input  logic             ALU_reg_write,
    input  logic             ALU_reg_sel,
    input  logic             flush,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             ready,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int AW = 2 * WIDTH + 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;
    localparam logic [3:0] OP_MUL = 4'hA;
    localparam logic [3:0] OP_DIV = 4'hB;
    localparam logic [3:0] OP_MF  = 4'hC;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? ((~v) + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? ((~v) + {{(2*WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    logic [1:0]         state_r;
    logic [CW-1:0]      cnt_r;
    logic [AW-1:0]      acc_r;
    logic [WIDTH-1:0]   b_mag_r;
    logic [WIDTH-1:0]   a_raw_r;
    logic               is_div_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic               div0_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               a_neg_s;
    logic               b_neg_s;
    logic               is_op_s;
    logic               accept_s;
    logic               reg_wr_s;
    logic [WIDTH:0]     mul_upper_s;
    logic [AW-1:0]      mul_next_s;
    logic [AW-1:0]      div_shift_s;
    logic [WIDTH+1:0]   div_trial_s;
    logic [AW-1:0]      div_next_s;
    logic [AW-1:0]      acc_next_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

    // Request decode and operand sign extraction at the accept edge.
    always_comb begin
        is_op_s  = (ALU_control == OP_MUL) || (ALU_control == OP_DIV);
        a_neg_s  = ~do_unsigned & operand_a[WIDTH-1];
        b_neg_s  = ~do_unsigned & operand_b[WIDTH-1];
        accept_s = (state_r == IDLE) & req & ~flush & ~ALU_reg_write & is_op_s;
        reg_wr_s = (state_r == IDLE) & req & ~flush & ALU_reg_write;
    end

    // One iteration step; the final HI/LO come from the step computed on the last edge.
    always_comb begin
        mul_upper_s = acc_r[0] ? (acc_r[AW-1:WIDTH] + {1'b0, b_mag_r}) : acc_r[AW-1:WIDTH];
        mul_next_s  = {1'b0, mul_upper_s, acc_r[WIDTH-1:1]};
        div_shift_s = {acc_r[AW-2:0], 1'b0};
        div_trial_s = {1'b0, div_shift_s[AW-1:WIDTH]} - {2'b00, b_mag_r};
        if (!div_trial_s[WIDTH+1]) begin
            div_next_s = {div_trial_s[WIDTH:0], div_shift_s[WIDTH-1:1], 1'b1};
        end else begin
            div_next_s = div_shift_s;
        end
        acc_next_s = is_div_r ? div_next_s : mul_next_s;
        prod_s     = cond_neg_wide(acc_next_s[2*WIDTH-1:0], neg_q_r);
        if (div0_r) begin
            res_hi_s = a_raw_r;
            res_lo_s = {WIDTH{1'b1}};
        end else if (is_div_r) begin
            res_hi_s = cond_neg(acc_next_s[2*WIDTH-1:WIDTH], neg_r_r);
            res_lo_s = cond_neg(acc_next_s[WIDTH-1:0], neg_q_r);
        end else begin
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Control FSM, iteration datapath and HI/LO ownership; flush wins over everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            acc_r    <= '0;
            b_mag_r  <= '0;
            a_raw_r  <= '0;
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            div0_r   <= 1'b0;
            done_r   <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        state_r  <= CALC;
                        cnt_r    <= '0;
                        acc_r    <= {{(WIDTH+1){1'b0}}, cond_neg(operand_a, a_neg_s)};
                        b_mag_r  <= cond_neg(operand_b, b_neg_s);
                        a_raw_r  <= operand_a;
                        is_div_r <= (ALU_control == OP_DIV);
                        neg_q_r  <= a_neg_s ^ b_neg_s;
                        neg_r_r  <= a_neg_s;
                        div0_r   <= (ALU_control == OP_DIV) && (operand_b == {WIDTH{1'b0}});
                    end else if (reg_wr_s) begin
                        if (ALU_reg_sel) begin
                            lo_r <= operand_a;
                        end else begin
                            hi_r <= operand_a;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                    end else begin
                        acc_r <= acc_next_s;
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        if (cnt_r == CNT_LAST) begin
                            state_r <= FIN;
                            done_r  <= 1'b1;
                            hi_r    <= res_hi_s;
                            lo_r    <= res_lo_s;
                        end
                    end
                end
                FIN: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready   = (state_r == IDLE);
    assign stall   = req & (is_op_s | (ALU_control == OP_MF) | ALU_reg_write) & (state_r != IDLE);
    assign done    = done_r;
    assign hi      = hi_r;
    assign lo      = lo_r;
    assign rd_data = ALU_reg_sel ? lo_r : hi_r;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit owning the HI/LO registers; consumes the decoded ALU control bundle (ALU_control, do_unsigned, ALU_reg_write, ALU_reg_sel).
- Executes mult/multu/div/divu over 32 iteration cycles, plus mthi/mtlo writes and mfhi/mflo reads. Requests a pipeline stall while busy.
- Sits beside the main ALU in the execute stage.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  1  execute stage presents a valid instruction this cycle
- ALU_control  input  4  4'hA mul, 4'hB div, 4'hC mfhi/mflo; other codes ignored
- do_unsigned  input  1  1 = unsigned mul/div
- ALU_reg_write  input  1  1 = mthi/mtlo (write operand_a to HI/LO)
- ALU_reg_sel  input  1  0 = HI, 1 = LO (read and write select)
- flush  input  1  abort an in-flight operation
- operand_a  input  WIDTH  rs (multiplicand/dividend, mthi/mtlo source)
- operand_b  input  WIDTH  rt (multiplier/divisor)
- ready  output  1  unit idle, can accept mul/div/mthi/mtlo
- stall  output  1  hold the pipeline
- done  output  1  one-cycle pulse: HI/LO just updated by mul/div
- rd_data  output  WIDTH  mfhi/mflo result
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi=lo=0, done=0, iteration counter=0. ready=1 and stall=0 while in reset.
- States:
  - IDLE: ready=1.
  - CALC: 32 cycles, counter 0..31.
  - FIN: 1 cycle, done=1.
- Transitions:
  - IDLE -> CALC on req & ALU_control ∈ {A,B} & ~ALU_reg_write. Latch operands and signs on that edge.
  - CALC -> FIN when counter=31; HI/LO written on this same edge.
  - FIN -> IDLE unconditionally.
- Timing: if a request is accepted in cycle T, CALC runs T+1..T+32. The new hi/lo are visible and done=1 in T+33. The earliest next accept is T+34.
- Signed handling: operands are converted to magnitudes at accept (do_unsigned=0). Signs are fixed at the FIN write.
- Multiply: {hi,lo} = full 2*WIDTH product (shift-add).
  - Signed: product negated when operand signs differ.
- Divide (restoring): lo = quotient, hi = remainder.
  - Signed: quotient negated when signs differ; remainder takes the dividend's sign.
- Divide by zero: lo = all ones, hi = operand_a (both signed and unsigned). Still takes full latency.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo = 0x80000000, hi = 0.
- mthi/mtlo: req & ALU_reg_write in IDLE writes operand_a to hi (sel=0) or lo (sel=1) on that edge. No state change, done stays 0.
- Read path: rd_data = ALU_reg_sel ? lo : hi, combinational from the registers.
- Stall: stall = req & (ALU_control ∈ {A,B,C} | ALU_reg_write) & (state != IDLE).
  - In FIN, stall=1. Reads unstall in IDLE and see the new values.
  - Writes or new ops attempted during CALC/FIN are ignored (held by the stall) and never corrupt state.
- flush:
  - Flush in CALC or FIN: return to IDLE next edge. HI/LO are not modified, unless the FIN write edge has already occurred. done is not pulsed.
  - Flush in IDLE: blocks acceptance that cycle.
- Simultaneous events:
  - flush with an accepting req: no accept.
  - Reset mid-CALC: immediate IDLE, hi=lo=0.
- Width rules: internal accumulator 2*WIDTH+1 bits. All negation is two's complement modulo the target width.

Test Plan:
- Signed mult (-3) × 7, req at T -> busy T+1..T+32, done=1 at T+33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; ready=1 at T+34.
- multu 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Division results:
  - div (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu 100 / 7 -> lo=0x0000000E, hi=0x00000002.
- Divide corner cases:
  - divu 5 / 0 -> lo=0xFFFFFFFF, hi=0x00000005.
  - div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Register access:
  - mthi 0x1234 in IDLE -> hi=0x1234 next cycle, lo unchanged.
  - mfhi request during CALC -> stall=1 through FIN; rd_data equals the new hi once stall drops.
  - mtlo attempted during CALC -> lo unchanged.
- Abort paths, with prior hi=0xAA, lo=0xBB:
  - flush at T+10 of a div -> IDLE at T+11, hi/lo keep 0xAA/0xBB, no done.
  - rst_n=0 at T+10 -> hi=lo=0, ready=1 immediately.
